// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engines: AXI encodings, stream IDs, page size,
// per-engine state enums and the burst-sizing helper.
package dma_pkg;

    localparam logic [2:0] AXI_SIZE_64    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int STREAM_ID_BSR = 0;
    localparam int STREAM_ID_ACT = 1;
    localparam int STREAM_ID_OUT = 2;

    localparam int PAGE_BYTES = 4096;

    typedef enum logic [2:0] {
        OD_IDLE,
        OD_SEND_ADDR,
        OD_WRITE_DATA,
        OD_WAIT_RESP,
        OD_DONE_STATE
    } out_dma_state_e;

    // beats = min(max_awlen+1, ceil(bytes_rem/8), bytes left in the 4KB page / 8); returns beats-1
    function automatic logic [7:0] dma_burst_awlen(input logic [11:0] page_off,
                                                   input logic [31:0] bytes_rem,
                                                   input logic [7:0]  max_awlen);
        logic [31:0] b_max;
        logic [31:0] b_rem;
        logic [31:0] b_page;
        logic [31:0] beats;
        b_max  = {24'd0, max_awlen} + 32'd1;
        b_rem  = (bytes_rem >> 3) + {31'd0, |bytes_rem[2:0]};
        b_page = (32'(PAGE_BYTES) - {20'd0, page_off}) >> 3;
        beats  = b_max;
        if (b_rem < beats)  beats = b_rem;
        if (b_page < beats) beats = b_page;
        return 8'(beats - 32'd1);
    endfunction

endpackage

// File: rtl/out_dma_if.sv
// AXI4 write-address / write-data / write-response channels as one bundle.
interface out_dma_if #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 64,
    parameter int AXI_ID_W   = 4
);

    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [7:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );

endinterface

// File: rtl/dma_prefetch_fifo.sv
// Two-entry prefetch FIFO between a 1-cycle-latency BRAM and an AXI W channel.
module dma_prefetch_fifo #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);

endmodule

// File: rtl/out_dma.sv
// Output-buffer BRAM to DDR AXI4 write DMA, one outstanding burst at a time.
// Optional OUT_DMA_WSTRB_TAIL_EN: partial-byte strobes on the final beat for non-multiple-of-8 lengths.
module out_dma
    import dma_pkg::*;
#(
    parameter int         AXI_ADDR_W = 32,
    parameter int         AXI_DATA_W = 64,
    parameter int         AXI_ID_W   = 4,
    parameter int         STREAM_ID  = STREAM_ID_OUT,
    parameter logic [7:0] BURST_LEN  = 8'd15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [AXI_ADDR_W-1:0] dst_addr,
    input  logic [31:0]           transfer_length,
    output logic                  done,
    output logic                  busy,
    output logic                  error,
    out_dma_if.master             axi,
    output logic                  out_re,
    output logic [AXI_ADDR_W-1:0] out_addr,
    input  logic [AXI_DATA_W-1:0] out_rdata
);

    out_dma_state_e        state_q, state_d;
    logic [AXI_ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [AXI_ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [31:0]           bytes_rem_q, bytes_rem_d;
    logic [7:0]            awlen_q, awlen_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [8:0]            rd_issued_q, rd_issued_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  awvalid_q, awvalid_d;
    logic                  bready_q, bready_d;

    logic [AXI_DATA_W-1:0] fifo_head;
    logic [1:0]            fifo_count;
    logic                  fifo_empty, fifo_full, fifo_flush;
    logic                  rd_en, wvalid, wlast, w_fire;
    logic [31:0]           len_eff;
    logic [11:0]           burst_bytes;
    logic [7:0]            wstrb;
    logic                  unused_ok;

`ifdef OUT_DMA_WSTRB_TAIL_EN
    assign len_eff = transfer_length;
    assign wstrb   = (bytes_rem_q < 32'd8) ? ((8'h01 << bytes_rem_q[2:0]) - 8'h01) : 8'hFF;
`else
    assign len_eff = {transfer_length[31:3] + {28'd0, |transfer_length[2:0]}, 3'b000};
    assign wstrb   = 8'hFF;

    always_ff @(posedge clk) begin
        if (rst_n && state_q == OD_IDLE && start)
            assert (transfer_length[2:0] == 3'b000)
            else $error("out_dma: transfer_length %0d is not a multiple of 8", transfer_length);
    end
`endif

    // Credit rule: FIFO occupancy plus the read in flight never exceeds the two entries.
    assign rd_en = (state_q == OD_SEND_ADDR || state_q == OD_WRITE_DATA) &&
                   (({1'b0, fifo_count} + {2'b00, rd_inflight_q}) < 3'd2) &&
                   (rd_issued_q < ({1'b0, awlen_q} + 9'd1));

    assign wvalid      = (state_q == OD_WRITE_DATA) && !fifo_empty;
    assign wlast       = (state_q == OD_WRITE_DATA) && (beat_cnt_q == awlen_q);
    assign w_fire      = wvalid && axi.wready;
    assign burst_bytes = ({4'd0, awlen_q} + 12'd1) << 3;

    dma_prefetch_fifo #(.DATA_W(AXI_DATA_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (rd_inflight_q),
        .push_data (out_rdata),
        .pop       (w_fire),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        // NOTE: every *_d takes a default first, so no branch can leave a latch behind.
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        out_addr_d    = out_addr_q;
        bytes_rem_d   = bytes_rem_q;
        awlen_d       = awlen_q;
        beat_cnt_d    = beat_cnt_q;
        rd_issued_d   = rd_issued_q;
        rd_inflight_d = rd_en;
        busy_d        = busy_q;
        done_d        = 1'b0;
        error_d       = error_q;
        awvalid_d     = awvalid_q;
        bready_d      = bready_q;
        fifo_flush    = 1'b0;

        if (rd_en) begin
            out_addr_d  = out_addr_q + AXI_ADDR_W'(1);
            rd_issued_d = rd_issued_q + 9'd1;
        end

        case (state_q)
            OD_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (transfer_length == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        cur_addr_d  = dst_addr;
                        bytes_rem_d = len_eff;
                        awlen_d     = dma_burst_awlen(dst_addr[11:0], len_eff, BURST_LEN);
                        busy_d      = 1'b1;
                        out_addr_d  = '0;
                        rd_issued_d = 9'd0;
                        beat_cnt_d  = 8'd0;
                        awvalid_d   = 1'b1;
                        state_d     = OD_SEND_ADDR;
                    end
                end
            end
            OD_SEND_ADDR: begin
                if (axi.awready) begin
                    awvalid_d = 1'b0;
                    state_d   = OD_WRITE_DATA;
                end
            end
            OD_WRITE_DATA: begin
                if (w_fire) begin
                    bytes_rem_d = (bytes_rem_q < 32'd8) ? 32'd0 : bytes_rem_q - 32'd8;
                    if (wlast) begin
                        beat_cnt_d = 8'd0;
                        bready_d   = 1'b1;
                        state_d    = OD_WAIT_RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            OD_WAIT_RESP: begin
                if (axi.bvalid) begin
                    bready_d   = 1'b0;
                    cur_addr_d = cur_addr_q + {{(AXI_ADDR_W-12){1'b0}}, burst_bytes};
                    if (axi.bresp != AXI_RESP_OKAY) begin
                        error_d    = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        fifo_flush = 1'b1;
                        state_d    = OD_IDLE;
                    end else if (bytes_rem_q == 32'd0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = OD_DONE_STATE;
                    end else begin
                        awlen_d     = dma_burst_awlen(cur_addr_d[11:0], bytes_rem_q, BURST_LEN);
                        rd_issued_d = 9'd0;
                        awvalid_d   = 1'b1;
                        state_d     = OD_SEND_ADDR;
                    end
                end
            end
            OD_DONE_STATE: state_d = OD_IDLE;
            default:       state_d = OD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= OD_IDLE;
            cur_addr_q    <= '0;
            out_addr_q    <= '0;
            bytes_rem_q   <= 32'd0;
            awlen_q       <= 8'd0;
            beat_cnt_q    <= 8'd0;
            rd_issued_q   <= 9'd0;
            rd_inflight_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            awvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            out_addr_q    <= out_addr_d;
            bytes_rem_q   <= bytes_rem_d;
            awlen_q       <= awlen_d;
            beat_cnt_q    <= beat_cnt_d;
            rd_issued_q   <= rd_issued_d;
            rd_inflight_q <= rd_inflight_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            awvalid_q     <= awvalid_d;
            bready_q      <= bready_d;
        end
    end

    assign axi.awid    = AXI_ID_W'(STREAM_ID);
    assign axi.awaddr  = cur_addr_q;
    assign axi.awlen   = awlen_q;
    assign axi.awsize  = AXI_SIZE_64;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wvalid ? fifo_head : '0;
    assign axi.wstrb   = wvalid ? wstrb : 8'h00;
    assign axi.wlast   = wlast;
    assign axi.wvalid  = wvalid;
    assign axi.bready  = bready_q;

    assign done     = done_q;
    assign busy     = busy_q;
    assign error    = error_q;
    assign out_re   = rd_en;
    assign out_addr = out_addr_q;

    assign unused_ok = ^{axi.bid, fifo_full};

endmodule

// File: tb/tb_out_dma.sv
// Directed bench for out_dma: page guard, stalls, error response, zero length, tail strobes.
module tb_out_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dst_addr = 32'd0;
    logic [31:0] transfer_length = 32'd0;
    logic        done, busy, error, out_re;
    logic [31:0] out_addr;
    logic [63:0] out_rdata;

    out_dma_if #(.AXI_ADDR_W(32), .AXI_DATA_W(64), .AXI_ID_W(4)) axi ();

    out_dma #(
        .AXI_ADDR_W (32),
        .AXI_DATA_W (64),
        .AXI_ID_W   (4),
        .STREAM_ID  (2),
        .BURST_LEN  (8'd15)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .dst_addr        (dst_addr),
        .transfer_length (transfer_length),
        .done            (done),
        .busy            (busy),
        .error           (error),
        .axi             (axi),
        .out_re          (out_re),
        .out_addr        (out_addr),
        .out_rdata       (out_rdata)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bram_word(input logic [31:0] a);
        return {8'hA5, a[23:0], ~a};
    endfunction

    always @(posedge clk) if (out_re) out_rdata <= bram_word(out_addr);

    // Slave modes and scoreboard, owned by the sampler below
    bit          aw_delay_mode = 1'b0;
    bit          wready_rand_mode = 1'b0;
    bit          bad_first_resp = 1'b0;
    int          test_id = 0;
    int          seen_test_id = 0;
    int          cyc = 0;
    int          aw_n, w_n, b_n, done_n, reads_n, done_cyc, b_cyc, stall_viol, credit_viol;
    int          aw_wait = 0;
    bit          b_pending, busy_seen, awvalid_seen, prev_stall;
    logic [63:0] prev_wdata;
    logic [63:0] last_mask;
    logic [31:0] aw_addr [16];
    logic [7:0]  aw_len  [16];
    logic [63:0] w_data  [64];
    logic [7:0]  w_strb  [64];

    initial axi.bid = 4'd0;

    always begin
        @(negedge clk);
        axi.awready = aw_delay_mode ? (aw_wait >= 5) : 1'b1;
        axi.wready  = wready_rand_mode ? ($urandom_range(99, 0) >= 30) : 1'b1;
        axi.bvalid  = b_pending;
        axi.bresp   = (bad_first_resp && b_n == 0) ? 2'b10 : 2'b00;
        #1;
        cyc++;
        if (seen_test_id != test_id) begin
            seen_test_id = test_id;
            aw_n = 0; w_n = 0; b_n = 0; done_n = 0; reads_n = 0;
            done_cyc = -1; b_cyc = -1; stall_viol = 0; credit_viol = 0;
            b_pending = 1'b0; busy_seen = 1'b0; awvalid_seen = 1'b0;
            prev_stall = 1'b0; last_mask = 64'd0;
        end
        if (rst_n) begin
            if (busy) busy_seen = 1'b1;
            if (axi.awvalid) awvalid_seen = 1'b1;
            if (done) begin done_n++; done_cyc = cyc; end
            if (axi.awvalid) begin
                if (axi.awready) begin
                    if (aw_n < 16) begin aw_addr[aw_n] = axi.awaddr; aw_len[aw_n] = axi.awlen; end
                    aw_n++;
                    aw_wait = 0;
                end else begin
                    aw_wait++;
                end
            end
            if ((reads_n - w_n) + int'(out_re) > 2) credit_viol++;
            if (out_re) reads_n++;
            if (prev_stall && (!axi.wvalid || axi.wdata !== prev_wdata)) stall_viol++;
            prev_stall = axi.wvalid && !axi.wready;
            prev_wdata = axi.wdata;
            if (axi.wvalid && axi.wready) begin
                if (w_n < 64) begin
                    w_data[w_n] = axi.wdata;
                    w_strb[w_n] = axi.wstrb;
                    last_mask[w_n] = axi.wlast;
                end
                w_n++;
                if (axi.wlast) b_pending = 1'b1;
            end
            if (axi.bvalid && axi.bready) begin
                b_n++;
                b_cyc = cyc;
                b_pending = 1'b0;
            end
        end
    end

    task automatic run_xfer(input string tag, input logic [31:0] addr, input logic [31:0] len,
                            output int start_cyc);
        test_id++;
        @(negedge clk); #2;
        dst_addr = addr;
        transfer_length = len;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk); #2;
        start = 1'b0;
        for (int i = 0; i < 4000 && done_n == 0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        #2;
        check({tag, " done pulses"}, 64'(done_n), 64'd1);
    endtask

    task automatic check_data(input string tag, input int n);
        for (int k = 0; k < n; k++) check({tag, " wdata"}, w_data[k], bram_word(32'(k)));
    endtask

    initial begin
        int sc;
        int strb_bad;
        #500_000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sc;
        int strb_bad;
        repeat (3) @(negedge clk);
        #2;
        check("reset done",    64'(done),        64'd0);
        check("reset busy",    64'(busy),        64'd0);
        check("reset error",   64'(error),       64'd0);
        check("reset awvalid", 64'(axi.awvalid), 64'd0);
        check("reset wvalid",  64'(axi.wvalid),  64'd0);
        check("reset wlast",   64'(axi.wlast),   64'd0);
        check("reset bready",  64'(axi.bready),  64'd0);
        check("reset out_re",  64'(out_re),      64'd0);
        check("reset out_addr", 64'(out_addr),   64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two full 16-beat bursts
        run_xfer("t1", 32'h1000, 32'd256, sc);
        check("t1 aw count", 64'(aw_n), 64'd2);
        check("t1 aw0 addr", 64'(aw_addr[0]), 64'h1000);
        check("t1 aw0 len",  64'(aw_len[0]),  64'd15);
        check("t1 aw1 addr", 64'(aw_addr[1]), 64'h1080);
        check("t1 aw1 len",  64'(aw_len[1]),  64'd15);
        check("t1 beats",    64'(w_n), 64'd32);
        check_data("t1", 32);
        check("t1 wlast mask", last_mask, 64'h0000_0000_8000_8000);
        strb_bad = 0;
        for (int k = 0; k < 32; k++) if (w_strb[k] != 8'hFF) strb_bad++;
        check("t1 wstrb not FF", 64'(strb_bad), 64'd0);
        check("t1 error", 64'(error), 64'd0);
        check("t1 busy after", 64'(busy), 64'd0);
        check("t1 fifo credit", 64'(credit_viol), 64'd0);

        // 4KB page guard splits at 0x1000
        run_xfer("t2", 32'h0FC0, 32'd128, sc);
        check("t2 aw count", 64'(aw_n), 64'd2);
        check("t2 aw0 addr", 64'(aw_addr[0]), 64'h0FC0);
        check("t2 aw0 len",  64'(aw_len[0]),  64'd7);
        check("t2 aw1 addr", 64'(aw_addr[1]), 64'h1000);
        check("t2 aw1 len",  64'(aw_len[1]),  64'd7);
        check("t2 beats",    64'(w_n), 64'd16);
        check_data("t2", 16);
        check("t2 wlast mask", last_mask, 64'h0000_0000_0000_8080);

        // Back-pressure on W and a delayed AW ready
        aw_delay_mode = 1'b1;
        wready_rand_mode = 1'b1;
        run_xfer("t3", 32'h2000, 32'd64, sc);
        aw_delay_mode = 1'b0;
        wready_rand_mode = 1'b0;
        check("t3 aw count", 64'(aw_n), 64'd1);
        check("t3 aw0 addr", 64'(aw_addr[0]), 64'h2000);
        check("t3 aw0 len",  64'(aw_len[0]),  64'd7);
        check("t3 beats",    64'(w_n), 64'd8);
        check_data("t3", 8);
        check("t3 wlast mask", last_mask, 64'h80);
        check("t3 stall stability", 64'(stall_viol), 64'd0);
        check("t3 fifo credit", 64'(credit_viol), 64'd0);

        // SLVERR on the first burst aborts the transfer
        bad_first_resp = 1'b1;
        run_xfer("t4", 32'h3000, 32'd256, sc);
        bad_first_resp = 1'b0;
        check("t4 aw count", 64'(aw_n), 64'd1);
        check("t4 b count",  64'(b_n), 64'd1);
        check("t4 beats",    64'(w_n), 64'd16);
        check("t4 error",    64'(error), 64'd1);
        check("t4 done after B", 64'(done_cyc), 64'(b_cyc + 1));
        check("t4 busy after", 64'(busy), 64'd0);

        run_xfer("t4b", 32'h4000, 32'd64, sc);
        check("t4b error cleared", 64'(error), 64'd0);
        check("t4b aw count", 64'(aw_n), 64'd1);
        check_data("t4b", 8);

        // Zero length: immediate done, no traffic
        run_xfer("t5", 32'h5000, 32'd0, sc);
        check("t5 done latency", 64'(done_cyc), 64'(sc + 1));
        check("t5 awvalid seen", 64'(awvalid_seen), 64'd0);
        check("t5 busy seen",    64'(busy_seen), 64'd0);
        check("t5 beats",        64'(w_n), 64'd0);

`ifdef OUT_DMA_WSTRB_TAIL_EN
        run_xfer("t6", 32'h6000, 32'd20, sc);
        check("t6 aw count", 64'(aw_n), 64'd1);
        check("t6 aw0 len",  64'(aw_len[0]), 64'd2);
        check("t6 beats",    64'(w_n), 64'd3);
        check("t6 wstrb0",   64'(w_strb[0]), 64'hFF);
        check("t6 wstrb1",   64'(w_strb[1]), 64'hFF);
        check("t6 wstrb2",   64'(w_strb[2]), 64'h0F);
        check_data("t6", 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
